// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler that owns the HI/LO pair and sequences MDU ops over fixed latencies.
// Optional multiply-accumulate ops (madd/maddu/msub/msubu) are enabled by defining MDU_MADD_EN.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        md_use_E,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        dbg_state_o
);
    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

    state_e      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

    // Issue handshake: start is a one-cycle offer; it is taken at the edge only when
    // busy is low and Req is low. Anything offered while busy is dropped silently.
    logic accept;
    logic is_mul, is_div, is_mac, is_long;
    assign accept = start & ~Req & ~busy_q;
    assign is_mul = (md_op == 4'd1) | (md_op == 4'd2);
    assign is_div = (md_op == 4'd3) | (md_op == 4'd4);
`ifdef MDU_MADD_EN
    assign is_mac = (md_op >= 4'd7) & (md_op <= 4'd10);
`else
    assign is_mac = 1'b0;
`endif
    assign is_long = is_mul | is_div | is_mac;

    logic [63:0] prod_s, prod_u;
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide via magnitudes so truncation is toward zero and the remainder follows the dividend.
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, q_s, r_s, q_u, r_u;
    assign a_mag  = A[31] ? (~A + 32'd1) : A;
    assign b_mag  = B[31] ? (~B + 32'd1) : B;
    assign b_safe = (B == 32'd0) ? 32'd1 : B;
    assign q_mag  = a_mag / ((b_mag == 32'd0) ? 32'd1 : b_mag);
    assign r_mag  = a_mag % ((b_mag == 32'd0) ? 32'd1 : b_mag);
    assign q_s    = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
    assign r_s    = A[31] ? (~r_mag + 32'd1) : r_mag;
    assign q_u    = A / b_safe;
    assign r_u    = A % b_safe;

    logic [63:0] result;
    always_comb begin
        result = 64'd0;
        case (md_op)
            4'd1: result = prod_s;
            4'd2: result = prod_u;
            4'd3: result = (B == 32'd0) ? {A, 32'hFFFF_FFFF} : {r_s, q_s};
            4'd4: result = (B == 32'd0) ? {A, 32'hFFFF_FFFF} : {r_u, q_u};
`ifdef MDU_MADD_EN
            4'd7:  result = {hi_q, lo_q} + prod_s;
            4'd8:  result = {hi_q, lo_q} + prod_u;
            4'd9:  result = {hi_q, lo_q} - prod_s;
            4'd10: result = {hi_q, lo_q} - prod_u;
`endif
            default: result = 64'd0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        case (state_q)
            S_IDLE: begin
                if (accept && is_long) begin
                    pend_hi_d = result[63:32];
                    pend_lo_d = result[31:0];
                    count_d   = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                    busy_d    = 1'b1;
                    state_d   = S_BUSY;
                end else if (accept && md_op == 4'd5) begin
                    hi_d = A;
                end else if (accept && md_op == 4'd6) begin
                    lo_d = A;
                end
            end
            S_BUSY: begin
                // Req is deliberately ignored here: the in-flight op is already committed.
                if (count_q == 4'd1) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    busy_d  = 1'b0;
                    count_d = 4'd0;
                    state_d = S_IDLE;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= 4'd0;
            busy_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign busy        = busy_q;
    assign HI          = hi_q;
    assign LO          = lo_q;
    assign dbg_state_o = state_q;
    assign stall_req   = md_use_E & (busy_q | (start & is_long & ~Req & ~busy_q));
endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multiply/divide scheduler owning the HI/LO register pair for the P7 pipeline.
- Accepts MDU operations issued from the E stage and sequences them over fixed multi-cycle latencies.
- Drives a busy/stall request to the hazard unit and feeds HI/LO read data back to the E-stage HILO path.
- Honors interrupt/exception flush (Req): a flushed instruction must never modify HI/LO.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- Req  input  1  exception/interrupt flush; the E-stage instruction in this cycle is cancelled
- start  input  1  E-stage instruction is an MDU op (qualifies md_op)
- md_op  input  4  1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; others no-op
- A  input  32  rs operand (forwarded)
- B  input  32  rt operand (forwarded)
- md_use_E  input  1  E-stage instruction is any of mult/div/mfhi/mflo/mthi/mtlo
- busy  output  1  long operation in flight
- stall_req  output  1  stall request to hazard unit
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- Interface: reset is synchronous and active-high; the clock is clk.
- Reset values: HI=0, LO=0, busy=0, count=0, state=IDLE, pending regs=0.
- Accept rule: an op is accepted at a posedge only when start=1 & Req=0 & reset=0 & busy=0. Otherwise it is ignored; start while busy is a hazard-unit error and has no effect.
- FSM states are IDLE and BUSY.
- IDLE + accepted mult/multu/div/divu:
  - Compute the result combinationally from A/B and latch it into pending_hi/pending_lo.
  - count<=N (N=MULT_CYCLES or DIV_CYCLES), busy<=1, go to BUSY.
- IDLE + accepted mthi/mtlo: HI<=A or LO<=A at that edge. No busy, stay IDLE.
- BUSY, each edge:
  - If count==1: HI<=pending_hi, LO<=pending_lo, busy<=0, count<=0, go to IDLE.
  - Else: count<=count-1.
- Timing: busy is high for exactly N cycles after the accept edge. The new HI/LO become visible at the same edge where busy falls.
- Req during BUSY does not abort. The in-flight op belongs to an older, committed instruction and must complete.
- Arithmetic, mult: signed 32x32 gives 64; {HI,LO}=product. multu is unsigned.
- Arithmetic, div: LO=quotient, HI=remainder, truncation toward zero, remainder takes the dividend's sign. divu is unsigned.
- Divide by zero: HI=A, LO=32'hFFFF_FFFF. The op still takes DIV_CYCLES.
- Overflow case 32'h8000_0000 / -1 (signed): LO=32'h8000_0000, HI=0.
- stall_req = md_use_E & (busy | (start & md_op in 1..4 & ~Req & ~busy)), combinational.
  - This holds the dependent instruction in E, including the accept cycle itself, so mfhi issued right after mult waits.
- Reset mid-operation: reset wins over everything. It discards pending and returns all outputs to reset values at that edge.
- mthi/mtlo with Req=1: no write.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: adds md_op 7 madd, 8 maddu, 9 msub, 10 msubu. {HI,LO} <= {HI,LO} +/- product, with signed or unsigned product per op. Uses MULT_CYCLES latency.
  - The accumulate base is the HI/LO value at the accept edge.
- Undefined: ops 7..10 are treated as no-ops (not accepted, no busy, no stall).

Test Plan:
- Reset, then mult A=32'hFFFF_FFFE (-2), B=3 -> busy high for 5 cycles; then HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA. stall_req=1 for mflo issued in each of those cycles.
- divu A=7, B=2 -> busy 10 cycles, then HI=1, LO=3. A second start at busy cycle 4 is ignored and the result is unchanged.
- div A=-7 (32'hFFFF_FFF9), B=2 -> LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF. div A=5, B=0 -> HI=5, LO=32'hFFFF_FFFF.
- mthi A=32'h1234_5678 with Req=1 -> HI unchanged. Repeat with Req=0 -> HI=32'h1234_5678 on the next edge with no busy.
- mult in flight, Req pulsed at busy cycle 2 -> completes normally. reset asserted at busy cycle 3 -> busy=0, HI=LO=0 at that edge.
- With MDU_MADD_EN: HI=0, LO=32'hFFFF_FFFF, then maddu A=1, B=1 -> HI=1, LO=0 after 5 cycles. Without the macro: op 8 -> no busy, HI/LO unchanged.
